// File: rtl/mdu_divider_seq_if.sv
// Request/response bundle between the multi-cycle control FSM (master)
// and the sequential RV32M divider (slave).
interface mdu_divider_seq_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_op;
    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_result;
    logic            busy;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, busy
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, busy
    );
endinterface

// File: rtl/mdu_divider_seq.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Operands are converted to magnitudes on acceptance, divided in 32
// iterations, and the signs / RISC-V special cases are applied in FIX.
// Optional build macro: DIVIDER_FAST_SPECIAL_EN -- divide-by-zero and
// signed-overflow requests bypass the iteration phase (FIX straight away).
//
// state | meaning
// IDLE  | ready for a request, operands latched on req_valid
// CALC  | one quotient bit per cycle, 32 cycles
// FIX   | sign correction / special-case override, result registered
// DONE  | result presented until rsp_ready
module mdu_divider_seq #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input logic               clk,
    input logic               reset,
    mdu_divider_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t          r_state;
    state_t          w_state_nxt;

    logic            r_want_rem;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_div0;
    logic            r_ovf;
    logic [XLEN-1:0] r_a_orig;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_acc;
    logic [XLEN-1:0] r_divisor;
    logic [XLEN-1:0] r_result;
    logic [CNT_W-1:0] r_cnt;

    logic            w_is_signed;
    logic            w_div0;
    logic            w_ovf;
    logic            w_neg_q;
    logic            w_neg_r;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic [XLEN:0]   w_acc_sh;
    logic [XLEN:0]   w_trial;
    logic            w_trial_neg;
    logic            w_last;
    logic [XLEN-1:0] w_quo_fix;
    logic [XLEN-1:0] w_rem_fix;

    // Operand decode for the request currently on the bus
    assign w_is_signed = ~bus.req_op[0];
    assign w_div0      = (bus.req_b == '0);
    assign w_ovf       = w_is_signed & (bus.req_a == MIN_NEG) & (bus.req_b == '1);
    assign w_neg_q     = w_is_signed & (bus.req_a[XLEN-1] ^ bus.req_b[XLEN-1]) & ~w_div0;
    assign w_neg_r     = w_is_signed & bus.req_a[XLEN-1];
    assign w_a_mag     = (w_is_signed & bus.req_a[XLEN-1]) ? -bus.req_a : bus.req_a;
    assign w_b_mag     = (w_is_signed & bus.req_b[XLEN-1]) ? -bus.req_b : bus.req_b;

    // The shifted partial remainder needs XLEN+1 bits when the divisor is
    // above 2^(XLEN-1); the top bit of the trial difference is its sign.
    assign w_acc_sh    = {r_acc, r_quo[XLEN-1]};
    assign w_trial     = w_acc_sh - {1'b0, r_divisor};
    assign w_trial_neg = w_trial[XLEN];
    assign w_last      = (r_cnt == '0);

    // Special cases override the iterated result
    assign w_quo_fix = r_div0 ? '1 :
                       r_ovf  ? MIN_NEG :
                       r_neg_q ? -r_quo : r_quo;
    assign w_rem_fix = r_div0 ? r_a_orig :
                       r_ovf  ? '0 :
                       r_neg_r ? -r_acc : r_acc;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.req_valid) begin
`ifdef DIVIDER_FAST_SPECIAL_EN
                    w_state_nxt = (w_div0 | w_ovf) ? ST_FIX : ST_CALC;
`else
                    w_state_nxt = ST_CALC;
`endif
                end
            end
            ST_CALC: begin
                if (w_last) begin
                    w_state_nxt = ST_FIX;
                end
            end
            ST_FIX:  w_state_nxt = ST_DONE;
            ST_DONE: begin
                if (bus.rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        bus.req_ready  = (r_state == ST_IDLE);
        bus.rsp_valid  = (r_state == ST_DONE);
        bus.busy       = (r_state != ST_IDLE);
        bus.rsp_result = r_result;
    end

    // Datapath: operand capture, iteration, result selection
    always_ff @(posedge clk) begin
        if (reset) begin
            r_want_rem <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div0     <= 1'b0;
            r_ovf      <= 1'b0;
            r_a_orig   <= '0;
            r_quo      <= '0;
            r_acc      <= '0;
            r_divisor  <= '0;
            r_result   <= '0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_want_rem <= bus.req_op[1];
                        r_neg_q    <= w_neg_q;
                        r_neg_r    <= w_neg_r;
                        r_div0     <= w_div0;
                        r_ovf      <= w_ovf;
                        r_a_orig   <= bus.req_a;
                        r_quo      <= w_a_mag;
                        r_acc      <= '0;
                        r_divisor  <= w_b_mag;
                        r_cnt      <= CNT_W'(XLEN - 1);
                    end
                end
                ST_CALC: begin
                    r_acc <= w_trial_neg ? w_acc_sh[XLEN-1:0] : w_trial[XLEN-1:0];
                    r_quo <= {r_quo[XLEN-2:0], ~w_trial_neg};
                    r_cnt <= r_cnt - 1'b1;
                end
                ST_FIX: begin
                    r_result <= r_want_rem ? w_rem_fix : w_quo_fix;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_divider_seq.sv
// Directed bench for mdu_divider_seq: literal expectations per vector plus a
// per-cycle monitor comparing handshake and result against an arithmetic model.
module tb_mdu_divider_seq;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    // Latency counted with the acceptance edge as cycle 1
    localparam int LAT_NORM = 34;
`ifdef DIVIDER_FAST_SPECIAL_EN
    localparam int LAT_SPEC = 2;
`else
    localparam int LAT_SPEC = 34;
`endif

    mdu_divider_seq_if #(.XLEN(32)) bus ();

    mdu_divider_seq #(.XLEN(32), .CNT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [31:0] sa, sb;
        logic [31:0] q, r;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (!op[0]) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
        return op[1] ? r : q;
    endfunction

    // Edges after the acceptance edge before rsp_valid is seen high
    function automatic int model_lat(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
        bit special;
        special = (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        return special ? LAT_SPEC - 1 : LAT_NORM - 1;
    endfunction

    typedef struct {
        logic [31:0] res;
        int          acc;
        int          lat;
    } exp_t;

    exp_t exp_q[$];

    // Per-cycle comparison of the DUT against the model
    always @(negedge clk) begin
        bit exp_idle;
        bit exp_rv;
        if (reset) begin
            exp_q.delete();
        end else begin
            exp_idle = (exp_q.size() == 0);
            exp_rv   = !exp_idle && (cyc >= exp_q[0].acc + exp_q[0].lat);
            chk("mon_req_ready", {31'd0, bus.req_ready}, {31'd0, exp_idle});
            chk("mon_busy", {31'd0, bus.busy}, {31'd0, !exp_idle});
            chk("mon_rsp_valid", {31'd0, bus.rsp_valid}, {31'd0, exp_rv});
            if (exp_rv) chk("mon_rsp_result", bus.rsp_result, exp_q[0].res);
            if (exp_rv && bus.rsp_ready) begin
                void'(exp_q.pop_front());
            end else if (exp_idle && bus.req_valid) begin
                exp_q.push_back('{res: model(bus.req_op, bus.req_a, bus.req_b),
                                  acc: cyc + 1,
                                  lat: model_lat(bus.req_op, bus.req_a, bus.req_b)});
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bit got;
        got = 1'b0;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            failures++;
            checks++;
            $display("FAIL issue_timeout: req_ready never high, want 1");
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            n++;
            if (bus.rsp_valid) break;
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] want, input int lat);
        int n;
        issue(op, a, b);
        wait_rsp(n);
        chk({name, "_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
        chk({name, "_result"}, bus.rsp_result, want);
        chk({name, "_latency"}, n, lat);
    endtask

    initial begin
        int n;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_a     = 32'd0;
        bus.req_b     = 32'd0;
        bus.rsp_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_rsp_result", bus.rsp_result, 32'd0);
        chk("reset_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);

        run_op("divu_100_7",  2'b01, 32'd100, 32'd7, 32'd14, LAT_NORM);
        run_op("remu_100_7",  2'b11, 32'd100, 32'd7, 32'd2, LAT_NORM);
        run_op("div_m100_7",  2'b00, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, LAT_NORM);
        run_op("rem_m100_7",  2'b10, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, LAT_NORM);
        run_op("div_5_0",     2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, LAT_SPEC);
        run_op("rem_5_0",     2'b10, 32'd5, 32'd0, 32'd5, LAT_SPEC);
        run_op("divu_min_0",  2'b01, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, LAT_SPEC);
        run_op("div_ovf",     2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_SPEC);
        run_op("rem_ovf",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, LAT_SPEC);
        run_op("div_m7_m2",   2'b00, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, LAT_NORM);
        run_op("rem_m7_m2",   2'b10, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, LAT_NORM);
        run_op("div_7_m2",    2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, LAT_NORM);
        run_op("rem_7_m2",    2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, LAT_NORM);
        run_op("divu_max_1",  2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, LAT_NORM);
        run_op("remu_max_max", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, LAT_NORM);
        run_op("divu_min_max", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, LAT_NORM);
        run_op("remu_min_max", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_NORM);
        run_op("divu_big",    2'b01, 32'hFFFF_FFFE, 32'hC000_0000, 32'd1, LAT_NORM);
        run_op("remu_big",    2'b11, 32'hFFFF_FFFE, 32'hC000_0000, 32'h3FFF_FFFE, LAT_NORM);

        // Back-pressure: result held, new request ignored while DONE
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        issue(2'b01, 32'd1000, 32'd10);
        wait_rsp(n);
        chk("bp_latency", n, LAT_NORM);
        for (int k = 0; k < 10; k++) begin
            if (k == 4) begin
                bus.req_valid = 1'b1;
                bus.req_op    = 2'b11;
                bus.req_a     = 32'd77;
                bus.req_b     = 32'd5;
            end
            if (k == 5) bus.req_valid = 1'b0;
            chk("bp_hold_result", bus.rsp_result, 32'd100);
            chk("bp_hold_req_ready", {31'd0, bus.req_ready}, 32'd0);
            chk("bp_hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
            @(posedge clk);
            #1;
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", {31'd0, bus.rsp_valid}, 32'd1);
        @(negedge clk);
        chk("bp_idle_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("bp_idle_busy", {31'd0, bus.busy}, 32'd0);
        chk("bp_idle_valid", {31'd0, bus.rsp_valid}, 32'd0);

        // Reset in the middle of CALC discards the operation
        issue(2'b01, 32'hDEAD_BEEF, 32'd3);
        repeat (14) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_mid_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_mid_result", bus.rsp_result, 32'd0);
        repeat (5) @(negedge clk);
        chk("rst_mid_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
        run_op("divu_9_3", 2'b01, 32'd9, 32'd3, 32'd3, LAT_NORM);

        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mdu_divider_seq.md
Name: mdu_divider_seq

Overview:
- Multi-cycle radix-2 restoring divider for the RV32M DIV, DIVU, REM and REMU instructions.
- Sits beside the combinational ALU inside the multi-cycle datapath.
- The control FSM issues an operation over a valid/ready request channel, stalls, and collects the result over a valid/ready response channel.
- Produces RISC-V-exact results, including divide-by-zero and signed-overflow cases.

Parameters:
- XLEN, 32, operand and result width. Only 32 is supported.
- CNT_W, 5, iteration counter width; equals log2(XLEN).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request strobe from control FSM.
- req_ready  output  1  divider idle, can accept a request.
- req_op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- req_a  input  32  dividend (rs1).
- req_b  input  32  divisor (rs2).
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer takes the result.
- rsp_result  output  32  quotient or remainder as selected by op.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: synchronous, active-high, named clk/reset. While reset=1 at an edge:
  - state returns to IDLE;
  - req_ready=1, rsp_valid=0, busy=0, rsp_result=0;
  - counter=0, internal registers cleared.
  - Reset mid-operation discards the operation; no response is produced.
- States:
  - IDLE: req_ready=1. On req_valid&&req_ready, latch op, a and b, and compute flags:
    - is_signed=~op[0]; want_rem=op[1];
    - neg_q = is_signed & (a[31]^b[31]) & (b!=0); neg_r = is_signed & a[31];
    - div0 = (b==0); ovf = is_signed & (a==32'h8000_0000) & (b==32'hFFFF_FFFF).
    - Load the |a| dividend shift register (two's-complement magnitude when signed) and the |b| divisor; remainder acc=0; counter=31. Go to CALC.
  - CALC: each cycle:
    - shift {acc,quo} left by 1;
    - trial = acc_shifted - {1'b0,divisor} in 33-bit arithmetic;
    - if trial is non-negative, acc=trial[31:0] and set quo[0]=1;
    - counter decrements. Go to FIX when counter==0 at the edge, giving exactly 32 iterations.
  - FIX: select the result and register it into rsp_result, then go to DONE:
    - div0: quotient=32'hFFFF_FFFF, remainder=a (original, unsigned bits);
    - ovf: quotient=32'h8000_0000, remainder=0;
    - otherwise: quotient = neg_q ? -quo : quo; remainder = neg_r ? -acc : acc.
    - rsp_result = want_rem ? remainder : quotient.
  - DONE: rsp_valid=1 and rsp_result held stable.
    - On rsp_ready, go to IDLE; rsp_valid drops the next cycle.
    - No new request is accepted in the same cycle (req_ready=0 in DONE).
- Latency:
  - Acceptance edge to rsp_valid high is 34 cycles (32 CALC + FIX + DONE entry).
  - If rsp_ready is already high, the next request is accepted 2 cycles after rsp_valid rises.
  - Minimum issue interval is 36 cycles.
- Handshake rules:
  - req_* is sampled only when req_ready=1; inputs are ignored in other states.
  - rsp_result is unchanged while rsp_valid=1 && rsp_ready=0 (back-pressure for any number of cycles).
  - busy = (state != IDLE).
- Arithmetic: all negation is 32-bit two's-complement with wrap. -(32'h8000_0000) = 32'h8000_0000; this never reaches the output except through the ovf path.

Optional Feature:
- DIVIDER_FAST_SPECIAL_EN
- Defined:
  - In IDLE, on acceptance with div0 or ovf set, skip CALC and enter FIX directly.
  - rsp_valid rises 2 cycles after acceptance.
  - Results are identical to the undefined build.
  - Normal operands still take 34 cycles.
- Undefined: every operation takes the full 34-cycle path; special cases are forced in FIX only.

Test Plan:
- DIVU a=100, b=7, then REMU with the same operands -> rsp_result=14 then 2; rsp_valid exactly 34 cycles after each acceptance.
- DIV a=-100 (32'hFFFF_FF9C), b=7 -> 32'hFFFF_FFF2 (-14). REM with the same operands -> 32'hFFFF_FFFE (-2), sign follows the dividend.
- DIV a=5, b=0 -> 32'hFFFF_FFFF. REM a=5, b=0 -> 5. DIVU a=32'h8000_0000, b=0 -> 32'hFFFF_FFFF. Latency is 2 cycles with DIVIDER_FAST_SPECIAL_EN, 34 cycles without.
- DIV a=32'h8000_0000, b=32'hFFFF_FFFF -> 32'h8000_0000; REM with the same operands -> 0.
- Back-pressure: hold rsp_ready=0 for 10 cycles after rsp_valid -> rsp_result stable, req_ready=0, and a req_valid pulse meanwhile is ignored. Raise rsp_ready -> IDLE the next cycle.
- Assert reset at CALC iteration 15 -> next cycle IDLE, rsp_valid=0, busy=0, req_ready=1. A fresh DIVU 9/3 then returns 3 with full latency.
